lru_replacement_unit: RTL
=========================

# lru_replacement_unit

Parametrised true-LRU replacement state for an N-way set-associative cache, one age vector and valid mask per cache index. Sits beside the tag/data arrays in the cache controller. It records hits and fills, handles invalidations, and returns a registered victim way for a queried index. A flush sweep FSM clears all indexes, and an optional lock mask excludes ways from replacement.

## Interface
Parameters:
- num_of_ways_log2, default 2: log2 of associativity; WAYS = 2**num_of_ways_log2.
- index_width, default 4: cache index width; DEPTH = 2**index_width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  starts the invalidate-all sweep; ignored while busy_o=1.
- busy_o  out  1  high while the sweep runs.
- access_en_i  in  1  records an access (hit or fill).
- access_index_i  in  index_width  index of the access.
- access_way_i  in  num_of_ways_log2  way accessed.
- access_fill_i  in  1  with access_en_i, also sets that way's valid bit.
- inval_en_i  in  1  invalidates one way.
- inval_index_i  in  index_width  index to invalidate.
- inval_way_i  in  num_of_ways_log2  way to invalidate.
- query_index_i  in  index_width  index whose victim is requested, sampled every cycle.
- victim_way_o  out  num_of_ways_log2  registered victim way.
- victim_ok_o  out  1  victim_way_o is usable.
- lock_mask_i  in  WAYS  1 = way locked. Present only with LRU_WAY_LOCK_EN.

## Operation
- State per index:
  - age[w], width num_of_ways_log2. Ages always form a permutation of 0..WAYS-1; 0 = MRU, WAYS-1 = LRU.
  - valid[w].
- Reset and flush value for every index: age[w]=w, valid=all zero.
- Access to way a with age A at index i:
  - Every way with age < A increments.
  - age[a] becomes 0.
  - If access_fill_i=1, valid[a] becomes 1.
- Invalidate of way v with age V at index i:
  - Every way with age > V decrements.
  - age[v] becomes WAYS-1.
  - valid[v] becomes 0.
- Victim selection for the queried index, computed on pre-update state:
  - If any way is invalid and not locked, pick the lowest-numbered such way.
  - Otherwise pick the unlocked way with the largest age.
  - If every way is locked: victim_way_o=0, victim_ok_o=0.
- Simultaneous events:
  - Access and invalidate to the same index in the same cycle: the access is applied and the invalidate is dropped.
  - Access and invalidate to different indexes: both are applied.
- FSM states IDLE and SWEEP:
  - IDLE->SWEEP on flush_i=1, with the sweep counter set to 0.
  - In SWEEP, one index is reset per cycle and the counter increments.
  - SWEEP->IDLE after index DEPTH-1 is reset; the counter wraps to 0.
  - access, inval and flush inputs are ignored in SWEEP.
- Asserting rst_ni low during SWEEP returns the FSM to IDLE immediately and resets all state.

## Timing
- Reset values: busy_o=0, victim_way_o=0, victim_ok_o=0, FSM=IDLE, counter=0.
- Victim latency is 1 cycle: victim_way_o and victim_ok_o after edge k reflect query_index_i and state as they were before edge k. Same-cycle updates become visible from edge k+1.
- State updates take effect on the rising edge on which the enable is sampled.
- busy_o rises on the edge after flush_i is sampled and stays high for exactly DEPTH cycles.
- victim_ok_o is 0 while busy_o=1.
- The first access is accepted on the edge after busy_o falls.

## Configuration
- LRU_WAY_LOCK_EN defined:
  - lock_mask_i port exists.
  - Locked ways are never chosen as victim.
  - Locked ways still age and still track valid.
- LRU_WAY_LOCK_EN undefined:
  - lock_mask_i port is absent and the logic behaves as an all-zero mask.
  - victim_ok_o = NOT busy (registered).

## Test plan
All scenarios use WAYS=4, DEPTH=16.
- Reset, then query index 5 -> victim_way_o=0, victim_ok_o=1 one cycle later.
- At index 12, fill ways 0,1,2,3 in order, then query 12 -> victim 0. Then access way 0 -> victim 1. Then access way 1 -> victim 2.
- After the fills at index 12, invalidate way 3 -> victim 3. In the same cycle, an access at index 12 way 3 plus an invalidate at index 12 way 3 -> way 3 valid, victim 0.
- Fill all ways at index 10, then assert flush_i -> busy_o high for 16 cycles. An access during the sweep has no effect. After the sweep, query 10 -> victim 0 with all ways invalid.
- Assert flush, then drop rst_ni at sweep cycle 5 -> busy_o=0 and victim_ok_o=0 immediately. After reset is released, all indexes are at reset state.
- With LRU_WAY_LOCK_EN: index 12 fully filled in order 0..3, lock_mask_i=4'b0001 -> victim 1. lock_mask_i=4'b1111 -> victim_ok_o=0, victim_way_o=0.

Source files
------------

// File: rtl/lru_replacement_unit.sv
// rtl/lru_replacement_unit.sv - true-LRU replacement state with flush sweep and registered victim
//
// Keeps one age permutation and one valid mask per cache index and reports a
// registered victim way for the queried index.
// Optional feature macro: LRU_WAY_LOCK_EN (adds lock_mask_i; locked ways are never victims).
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   flush_i / busy_o              start invalidate-all sweep / sweep in progress
//   access_en_i, access_index_i,
//   access_way_i, access_fill_i   hit or fill: make way MRU, fill also sets valid
//   inval_en_i, inval_index_i,
//   inval_way_i                   invalidate one way: make it LRU and clear valid
//   query_index_i                 index whose victim is reported next cycle
//   victim_way_o, victim_ok_o     registered victim way and its usability
//   lock_mask_i                   per-way lock (LRU_WAY_LOCK_EN only)

module lru_replacement_unit #(
  parameter int num_of_ways_log2 = 2,
  parameter int index_width      = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  output logic                          busy_o,
  input  logic                          access_en_i,
  input  logic [index_width-1:0]        access_index_i,
  input  logic [num_of_ways_log2-1:0]   access_way_i,
  input  logic                          access_fill_i,
  input  logic                          inval_en_i,
  input  logic [index_width-1:0]        inval_index_i,
  input  logic [num_of_ways_log2-1:0]   inval_way_i,
  input  logic [index_width-1:0]        query_index_i,
`ifdef LRU_WAY_LOCK_EN
  input  logic [(2**num_of_ways_log2)-1:0] lock_mask_i,
`endif
  output logic [num_of_ways_log2-1:0]   victim_way_o,
  output logic                          victim_ok_o
);

  localparam int WAYS  = 2 ** num_of_ways_log2;
  localparam int DEPTH = 2 ** index_width;

  typedef logic [num_of_ways_log2-1:0] age_t;
  typedef enum logic {IDLE, SWEEP} state_t;

  localparam age_t AGE_ONE = age_t'(1);
  localparam age_t AGE_MAX = age_t'(WAYS - 1);

  age_t                 age_q   [DEPTH][WAYS];
  logic [WAYS-1:0]      valid_q [DEPTH];

  state_t               state_q, state_d;
  logic [index_width-1:0] cnt_q, cnt_d;

  logic                 sweep;
  logic                 acc_go, inv_go;
  age_t                 acc_age, inv_age;

  logic [WAYS-1:0]      lock_w;
  logic                 have_inv, have_any;
  age_t                 best_age;
  age_t                 victim_way_d;
  logic                 victim_ok_d;
  age_t                 victim_way_q;
  logic                 victim_ok_q;

`ifdef LRU_WAY_LOCK_EN
  assign lock_w = lock_mask_i;
`else
  assign lock_w = '0;
`endif

  // FSM: state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (flush_i) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        cnt_d = cnt_q + 1'b1;  // wraps to 0 after the last index
        if (&cnt_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    sweep  = (state_q == SWEEP);
    busy_o = sweep;
  end

  // An access wins over an invalidate aimed at the same index.
  assign acc_go  = !sweep && access_en_i;
  assign inv_go  = !sweep && inval_en_i &&
                   !(access_en_i && (access_index_i == inval_index_i));
  assign acc_age = age_q[access_index_i][access_way_i];
  assign inv_age = age_q[inval_index_i][inval_way_i];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int w = 0; w < WAYS; w++) age_q[i][w] <= age_t'(w);
        valid_q[i] <= '0;
      end
    end else begin
      if (sweep) begin
        for (int w = 0; w < WAYS; w++) age_q[cnt_q][w] <= age_t'(w);
        valid_q[cnt_q] <= '0;
      end
      if (acc_go) begin
        for (int w = 0; w < WAYS; w++) begin
          if (age_t'(w) == access_way_i)
            age_q[access_index_i][w] <= '0;
          else if (age_q[access_index_i][w] < acc_age)
            age_q[access_index_i][w] <= age_q[access_index_i][w] + AGE_ONE;
        end
        if (access_fill_i) valid_q[access_index_i][access_way_i] <= 1'b1;
      end
      if (inv_go) begin
        for (int w = 0; w < WAYS; w++) begin
          if (age_t'(w) == inval_way_i)
            age_q[inval_index_i][w] <= AGE_MAX;
          else if (age_q[inval_index_i][w] > inv_age)
            age_q[inval_index_i][w] <= age_q[inval_index_i][w] - AGE_ONE;
        end
        valid_q[inval_index_i][inval_way_i] <= 1'b0;
      end
    end
  end

  // Victim: lowest invalid unlocked way, else oldest unlocked way.
  always_comb begin
    have_inv     = 1'b0;
    have_any     = 1'b0;
    best_age     = '0;
    victim_way_d = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!lock_w[w] && !valid_q[query_index_i][w] && !have_inv) begin
        have_inv     = 1'b1;
        victim_way_d = age_t'(w);
      end
    end
    if (!have_inv) begin
      for (int w = 0; w < WAYS; w++) begin
        if (!lock_w[w] && (!have_any || age_q[query_index_i][w] > best_age)) begin
          have_any     = 1'b1;
          best_age     = age_q[query_index_i][w];
          victim_way_d = age_t'(w);
        end
      end
    end
    if (!(have_inv || have_any)) victim_way_d = '0;
    // Using the next FSM state keeps victim_ok_o low on every busy cycle.
    victim_ok_d = (have_inv || have_any) && (state_d == IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      victim_way_q <= '0;
      victim_ok_q  <= 1'b0;
    end else begin
      victim_way_q <= victim_way_d;
      victim_ok_q  <= victim_ok_d;
    end
  end

  assign victim_way_o = victim_way_q;
  assign victim_ok_o  = victim_ok_q;

endmodule
